// File: rtl/mult_div_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states and default width.
package mult_div_pkg;

   localparam int unsigned MD_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/sign_magnitude.sv
// Conditional two's-complement negate: used to take operand magnitudes and to sign-correct results.
module sign_magnitude
   import mult_div_pkg::*;
#(
   parameter int unsigned W = MD_WIDTH
) (
   input  logic [W-1:0] value_i,
   input  logic         negate_i,
   output logic [W-1:0] result_o
);

   assign result_o = negate_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULTU/MULT/DIVU/DIV unit with HI/LO result registers; stalls the PC while running.
// Define MULT_DIV_DIVIDE_EN to build the divider; without it divide Starts are ignored.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int unsigned N = MD_WIDTH
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         Start,
   input  logic [1:0]   Op,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         Stall,
   output logic         Busy,
   output logic         Done,
   output logic         DivZero,
   output logic [N-1:0] HI,
   output logic [N-1:0] LO
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   md_state_e      state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   a_mag_q, a_mag_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic           neg_lo_q, neg_lo_d;
   logic [N-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic           busy_q, busy_d, done_q, done_d;

   logic           op_ok, accept, last;
   logic [N-1:0]   a_mag_in, b_mag_in, res_hi, res_lo;
   logic [N:0]     mul_sum;
   logic [2*N-1:0] mul_next, prod_fix, step_next;

   sign_magnitude #(.W(N)) u_a_mag (
      .value_i (A),
      .negate_i(Op[0] & A[N-1]),
      .result_o(a_mag_in)
   );

   sign_magnitude #(.W(N)) u_b_mag (
      .value_i (B),
      .negate_i(Op[0] & B[N-1]),
      .result_o(b_mag_in)
   );

   // Shift-add: the multiplier sits in the low half and is consumed LSB first.
   assign mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
   assign mul_next = {mul_sum, acc_q[N-1:1]};

   sign_magnitude #(.W(2*N)) u_prod_fix (
      .value_i (mul_next),
      .negate_i(neg_lo_q),
      .result_o(prod_fix)
   );

`ifdef MULT_DIV_DIVIDE_EN
   md_op_e         op_q, op_d;
   logic [N-1:0]   b_mag_q, b_mag_d;
   logic           neg_hi_q, neg_hi_d;
   logic           dz_q, dz_d;
   logic           is_div, div_zero, div_fits, dz_flag;
   logic [N:0]     shift_rem, div_diff;
   logic [2*N-1:0] div_next;
   logic [N-1:0]   hi_src, quo_fix, rem_fix;

   assign op_ok    = 1'b1;
   assign is_div   = op_q inside {OP_DIVU, OP_DIV};
   assign div_zero = (b_mag_q == '0);

   // Restoring divide: remainder in the high half, dividend shifts out of / quotient into the low half.
   assign shift_rem = {acc_q[2*N-1:N], acc_q[N-1]};
   assign div_diff  = shift_rem - {1'b0, b_mag_q};
   assign div_fits  = ~div_diff[N];
   assign div_next  = div_fits ? {div_diff[N-1:0], acc_q[N-2:0], 1'b1}
                               : {shift_rem[N-1:0], acc_q[N-2:0], 1'b0};

   // On divide-by-zero, re-applying the dividend sign to its magnitude restores A exactly.
   assign hi_src = div_zero ? a_mag_q : div_next[2*N-1:N];

   sign_magnitude #(.W(N)) u_rem_fix (
      .value_i (hi_src),
      .negate_i(neg_hi_q),
      .result_o(rem_fix)
   );

   sign_magnitude #(.W(N)) u_quo_fix (
      .value_i (div_next[N-1:0]),
      .negate_i(neg_lo_q),
      .result_o(quo_fix)
   );

   assign step_next = is_div ? div_next : mul_next;
   assign res_hi    = is_div ? rem_fix : prod_fix[2*N-1:N];
   assign res_lo    = is_div ? (div_zero ? '1 : quo_fix) : prod_fix[N-1:0];
   assign dz_flag   = is_div & div_zero;

   always_comb begin
      op_d     = op_q;
      b_mag_d  = b_mag_q;
      neg_hi_d = neg_hi_q;
      dz_d     = 1'b0;
      if (accept) begin
         op_d     = md_op_e'(Op);
         b_mag_d  = b_mag_in;
         neg_hi_d = Op[0] & A[N-1];
      end
      if (state_q == RUN && last) dz_d = dz_flag;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q     <= OP_MULTU;
         b_mag_q  <= '0;
         neg_hi_q <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         op_q     <= op_d;
         b_mag_q  <= b_mag_d;
         neg_hi_q <= neg_hi_d;
         dz_q     <= dz_d;
      end
   end

   assign DivZero = dz_q;
`else
   assign op_ok     = ~Op[1];
   assign step_next = mul_next;
   assign res_hi    = prod_fix[2*N-1:N];
   assign res_lo    = prod_fix[N-1:0];
   assign DivZero   = 1'b0;
`endif

   assign accept = (state_q == IDLE) && Start && op_ok;
   assign last   = (cnt_q == CW'(N-1));
   assign Stall  = accept || (state_q == RUN);

   // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_mag_d  = a_mag_q;
      acc_d    = acc_q;
      neg_lo_d = neg_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = RUN;
               cnt_d    = '0;
               a_mag_d  = a_mag_in;
               acc_d    = {{N{1'b0}}, (Op[1] ? a_mag_in : b_mag_in)};
               neg_lo_d = Op[0] & (A[N-1] ^ B[N-1]);
            end
         end
         RUN: begin
            acc_d = step_next;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               state_d = DONE;
               hi_d    = res_hi;
               lo_d    = res_lo;
               done_d  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
   end

   // NOTE: state elements use non-blocking assignment so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_mag_q  <= '0;
         acc_q    <= '0;
         neg_lo_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_mag_q  <= a_mag_d;
         acc_q    <= acc_d;
         neg_lo_q <= neg_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle-level behavioural model plus directed literal checks.
// Expectations follow MULT_DIV_DIVIDE_EN the same way the design does.
`timescale 1ns/1ps
module tb_mult_div_unit;
   import mult_div_pkg::*;

   localparam int N = 32;
`ifdef MULT_DIV_DIVIDE_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset, Start;
   logic [1:0]   Op;
   logic [N-1:0] A, B;
   logic         Stall, Busy, Done, DivZero;
   logic [N-1:0] HI, LO;

   always #5 clk = ~clk;

   mult_div_unit #(.N(N)) dut (
      .clk    (clk),
      .reset  (reset),
      .Start  (Start),
      .Op     (Op),
      .A      (A),
      .B      (B),
      .Stall  (Stall),
      .Busy   (Busy),
      .Done   (Done),
      .DivZero(DivZero),
      .HI     (HI),
      .LO     (LO)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: how many busy cycles remain, whether the done cycle is showing, and the architectural outputs.
   int           m_run_left = 0;
   bit           m_in_done  = 1'b0;
   bit           m_done = 1'b0, m_dz = 1'b0, m_pend_dz = 1'b0;
   logic [N-1:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void ref_result(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                      output logic [N-1:0] hi, output logic [N-1:0] lo, output bit dz);
      logic [2*N-1:0] p;
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      hi = '0;
      lo = '0;
      case (op)
         2'b00: begin
            p  = {{N{1'b0}}, a} * {{N{1'b0}}, b};
            hi = p[2*N-1:N];
            lo = p[N-1:0];
         end
         2'b01: begin
            q  = sa * sb;
            hi = q[2*N-1:N];
            lo = q[N-1:0];
         end
         default: begin
            if (b == '0) begin
               dz = 1'b1;
               hi = a;
               lo = '1;
            end else if (op == 2'b10) begin
               lo = a / b;
               hi = a % b;
            end else begin
               q  = sa / sb;
               r  = sa % sb;
               lo = q[N-1:0];
               hi = r[N-1:0];
            end
         end
      endcase
   endfunction

   // One clock: drive inputs, check Stall, take the edge, advance the model, check registered outputs.
   task automatic tick(input bit st, input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit rst);
      bit idle, acc;
      Start = st;
      Op    = op;
      A     = a;
      B     = b;
      reset = rst;
      idle  = (m_run_left == 0) && !m_in_done;
      acc   = idle && st && (DIV_EN || !op[1]);
      #1;
      check("stall", {63'd0, Stall}, {63'd0, acc || (m_run_left > 0)});
      @(posedge clk);
      if (rst) begin
         m_run_left = 0;
         m_in_done  = 1'b0;
         m_hi       = '0;
         m_lo       = '0;
         m_done     = 1'b0;
         m_dz       = 1'b0;
      end else if (m_in_done) begin
         m_in_done = 1'b0;
         m_done    = 1'b0;
         m_dz      = 1'b0;
      end else if (m_run_left > 0) begin
         m_run_left--;
         if (m_run_left == 0) begin
            m_in_done = 1'b1;
            m_hi      = m_pend_hi;
            m_lo      = m_pend_lo;
            m_done    = 1'b1;
            m_dz      = m_pend_dz;
         end
      end else begin
         m_done = 1'b0;
         m_dz   = 1'b0;
         if (acc) begin
            m_run_left = N;
            ref_result(op, a, b, m_pend_hi, m_pend_lo, m_pend_dz);
         end
      end
      #1;
      check("busy", {63'd0, Busy}, {63'd0, m_run_left > 0});
      check("done", {63'd0, Done}, {63'd0, m_done});
      check("divzero", {63'd0, DivZero}, {63'd0, m_dz});
      check("hi", {32'd0, HI}, {32'd0, m_hi});
      check("lo", {32'd0, LO}, {32'd0, m_lo});
   endtask

   // Issue one operation and run until the IDLE cycle after DONE; operands change after the accepting edge.
   task automatic run_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         output int busy_cnt, output int done_idx, output int dz_cnt);
      busy_cnt = 0;
      done_idx = -1;
      dz_cnt   = 0;
      for (int i = 0; i < N + 2; i++) begin
         tick(i == 0, op, (i == 0) ? a : $urandom, (i == 0) ? b : $urandom, 1'b0);
         if (Busy) busy_cnt++;
         if (Done) done_idx = i;
         if (DivZero) dz_cnt++;
      end
   endtask

   function automatic logic [N-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return N'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt, done_idx, dz_cnt, done_seen;

      reset = 1'b1;
      Start = 1'b0;
      Op    = 2'b00;
      A     = '0;
      B     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {63'd0, Busy}, 64'd0);
      check("reset_done", {63'd0, Done}, 64'd0);
      check("reset_hi", {32'd0, HI}, 64'd0);
      check("reset_lo", {32'd0, LO}, 64'd0);
      tick(1'b0, 2'b00, '0, '0, 1'b0);

      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy_cnt, done_idx, dz_cnt);
      check("multu_hi", {32'd0, HI}, 64'hFFFF_FFFE);
      check("multu_lo", {32'd0, LO}, 64'h0000_0001);
      check("multu_done_cycle", 64'(done_idx), 64'(N));

      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, busy_cnt, done_idx, dz_cnt);
      check("mult_hi", {32'd0, HI}, 64'hFFFF_FFFF);
      check("mult_lo", {32'd0, LO}, 64'hFFFF_FFEB);
      check("mult_busy_cycles", 64'(busy_cnt), 64'd32);

`ifdef MULT_DIV_DIVIDE_EN
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, busy_cnt, done_idx, dz_cnt);
      check("div_lo", {32'd0, LO}, 64'hFFFF_FFFD);
      check("div_hi", {32'd0, HI}, 64'hFFFF_FFFF);
      run_op(OP_DIVU, 32'd100, 32'd7, busy_cnt, done_idx, dz_cnt);
      check("divu_lo", {32'd0, LO}, 64'd14);
      check("divu_hi", {32'd0, HI}, 64'd2);
      run_op(OP_DIVU, 32'd100, 32'd0, busy_cnt, done_idx, dz_cnt);
      check("divz_lo", {32'd0, LO}, 64'hFFFF_FFFF);
      check("divz_hi", {32'd0, HI}, 64'd100);
      check("divz_pulses", 64'(dz_cnt), 64'd1);
      check("divz_done_cycle", 64'(done_idx), 64'(N));
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, busy_cnt, done_idx, dz_cnt);
      check("div_ovf_lo", {32'd0, LO}, 64'h8000_0000);
      check("div_ovf_hi", {32'd0, HI}, 64'd0);
`else
      run_op(OP_DIVU, 32'd100, 32'd0, busy_cnt, done_idx, dz_cnt);
      check("nodiv_busy", 64'(busy_cnt), 64'd0);
      check("nodiv_done", 64'(done_idx), 64'hFFFF_FFFF_FFFF_FFFF);
      check("nodiv_hi", {32'd0, HI}, 64'hFFFF_FFFF);
      check("nodiv_lo", {32'd0, LO}, 64'hFFFF_FFEB);
`endif

      // Start held high through RUN and DONE: one completion, re-accepted in the IDLE cycle after DONE.
      done_seen = 0;
      for (int i = 0; i < N + 3; i++) begin
         tick(1'b1, OP_MULTU, 32'd3, 32'd5, 1'b0);
         if (Done) done_seen++;
         if (i == N + 1) check("held_idle_busy", {63'd0, Busy}, 64'd0);
         if (i == N + 2) check("held_reaccept_busy", {63'd0, Busy}, 64'd1);
      end
      check("held_done_pulses", 64'(done_seen), 64'd1);
      for (int i = 0; i < N + 1; i++) tick(1'b0, OP_MULTU, $urandom, $urandom, 1'b0);
      check("held_hi", {32'd0, HI}, 64'd0);
      check("held_lo", {32'd0, LO}, 64'd15);

      // Reset in RUN cycle 10 aborts the operation and clears HI/LO.
      tick(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      for (int i = 0; i < 9; i++) tick(1'b0, OP_MULTU, '0, '0, 1'b0);
      tick(1'b0, OP_MULTU, '0, '0, 1'b1);
      check("abort_busy", {63'd0, Busy}, 64'd0);
      check("abort_lo", {32'd0, LO}, 64'd0);
      done_seen = 0;
      for (int i = 0; i < N + 2; i++) begin
         tick(1'b0, OP_MULTU, '0, '0, 1'b0);
         if (Done) done_seen++;
      end
      check("abort_no_done", 64'(done_seen), 64'd0);

      // Random traffic: random Start density, ops, corner operands and occasional resets.
      for (int i = 0; i < 2500; i++) begin
         tick($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
              $urandom_range(0, 299) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
